// File: rtl/ps_requester4.sv
// Requester-side agent for a 4-way priority selector: per-client IDLE/REQ/OWN FSMs, one shared burst counter.
// Optional per-client starvation flags are built when REQ_STARVE_DETECT_EN is defined.
module ps_requester4 #(
    parameter int BURST_LEN    = 4,
    parameter int CNT_W        = 8
`ifdef REQ_STARVE_DETECT_EN
    ,
    parameter int STARVE_LIMIT = 16
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] job_valid,
    output logic [3:0] job_ready,
    output logic [3:0] req,
    output logic       en,
    input  logic [3:0] gnt,
    input  logic       req_up,
    output logic [1:0] owner,
    output logic       busy,
    output logic [3:0] done,
    output logic       err,
    output logic [3:0] starve
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_OWN  = 2'd2
    } state_t;

    state_t           state    [4];
    state_t           state_nx [4];
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;

    logic       gnt_any;
    logic       gnt_onehot;
    logic [1:0] gnt_idx;
    logic       gnt_target_req;
    logic       req_mismatch;
    logic       proto_err;
    logic       take;

    // The selector is locked while a burst runs, so a new grant can never overlap a burst end.
    assign en = ~busy;

    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        gnt_any    = |gnt;
        gnt_onehot = gnt_any && ((gnt & (gnt - 4'd1)) == 4'd0);
        gnt_idx    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (gnt[i]) gnt_idx = 2'(i);
        end
        gnt_target_req = (state[gnt_idx] == S_REQ);
        req_mismatch   = en && (req_up != (|req));

        proto_err = (gnt_any && !en)
                 || (gnt_any && !gnt_onehot)
                 || (en && gnt_onehot && !gnt_target_req)
                 || req_mismatch;
        // Any protocol violation voids the grant in that cycle.
        take = en && gnt_onehot && gnt_target_req && !req_mismatch;

        cnt_nx = cnt;
        if (take)
            cnt_nx = CNT_W'(BURST_LEN - 1);
        else if (busy && cnt != '0)
            cnt_nx = cnt - 1'b1;

        for (int i = 0; i < 4; i++) begin
            state_nx[i] = state[i];
            case (state[i])
                S_IDLE:  if (job_valid[i])     state_nx[i] = S_REQ;
                S_REQ:   if (take && gnt[i])   state_nx[i] = S_OWN;
                S_OWN:   if (cnt == '0)        state_nx[i] = S_IDLE;
                default:                       state_nx[i] = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next-state decode so they line up with the state they describe.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) state[i] <= S_IDLE;
            cnt       <= '0;
            req       <= 4'b0000;
            job_ready <= 4'b1111;
            busy      <= 1'b0;
            owner     <= 2'd0;
            done      <= 4'b0000;
            err       <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state[i]     <= state_nx[i];
                req[i]       <= (state_nx[i] == S_REQ);
                job_ready[i] <= (state_nx[i] == S_IDLE);
                done[i]      <= (state_nx[i] == S_OWN) && (cnt_nx == '0);
            end
            cnt   <= cnt_nx;
            busy  <= (state_nx[0] == S_OWN) || (state_nx[1] == S_OWN)
                  || (state_nx[2] == S_OWN) || (state_nx[3] == S_OWN);
            if (take) owner <= gnt_idx;
            err   <= err | proto_err;
        end
    end

`ifdef REQ_STARVE_DETECT_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] wait_cnt [4];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (state[i] == S_REQ && state_nx[i] == S_REQ) begin
                    if (wait_cnt[i] != SW'(STARVE_LIMIT)) wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end else begin
                    wait_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) starve[i] = (wait_cnt[i] == SW'(STARVE_LIMIT));
    end
`else
    assign starve = 4'b0000;
`endif

endmodule

// File: tb/tb_ps_requester4.sv
// Directed bench for ps_requester4 with a behavioural highest-index-first selector and a done-pulse scoreboard.
module tb_ps_requester4;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] job_valid;
    logic [3:0] job_ready;
    logic [3:0] req;
    logic       en;
    logic [3:0] gnt;
    logic       req_up;
    logic [1:0] owner;
    logic       busy;
    logic [3:0] done;
    logic       err;
    logic [3:0] starve;

    logic       force_on;
    logic [3:0] force_gnt;
    logic [3:0] sel_gnt;

    ps_requester4 dut (
        .clock    (clock),
        .reset    (reset),
        .job_valid(job_valid),
        .job_ready(job_ready),
        .req      (req),
        .en       (en),
        .gnt      (gnt),
        .req_up   (req_up),
        .owner    (owner),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .starve   (starve)
    );

    always #5 clock = ~clock;

    // Selector model: highest requesting index wins, nothing granted while en is low.
    always_comb begin
        sel_gnt = 4'b0000;
        if (en) begin
            if      (req[3]) sel_gnt = 4'b1000;
            else if (req[2]) sel_gnt = 4'b0100;
            else if (req[1]) sel_gnt = 4'b0010;
            else if (req[0]) sel_gnt = 4'b0001;
        end
    end
    assign gnt    = force_on ? force_gnt : sel_gnt;
    assign req_up = |req;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int client;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;
    bit   mon_on;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    // Offers a one-cycle job vector; returns on the following negedge.
    task automatic drive_jobs(input logic [3:0] v);
        job_valid = v;
        tick();
        job_valid = 4'b0000;
    endtask

    always @(negedge clock) begin
        if (mon_on && !reset && done !== 4'b0000) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("done_vec",   32'(done), 32'd1 << e.client);
                check("done_cycle", 32'(cyc),  32'(e.cyc));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset     = 1'b1;
        job_valid = 4'b0000;
        force_on  = 1'b0;
        force_gnt = 4'b0000;
        mon_on    = 1'b1;

        // Reset state
        tick(2);
        check("rst_job_ready", 32'(job_ready), 32'hF);
        check("rst_req",       32'(req),       32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        check("rst_en",        32'(en),        32'h1);
        check("rst_owner",     32'(owner),     32'h0);
        check("rst_done",      32'(done),      32'h0);
        check("rst_err",       32'(err),       32'h0);
        check("rst_starve",    32'(starve),    32'h0);
        reset = 1'b0;
        tick();

        // Single uncontended job on client 2
        n = cyc;
        sb.push_back('{2, n + 5});
        drive_jobs(4'b0100);
        check("t1_req",       32'(req),       32'b0100);
        check("t1_job_ready", 32'(job_ready), 32'b1011);
        tick();
        for (int k = 0; k < 4; k++) begin
            check("t1_busy",  32'(busy),  32'h1);
            check("t1_owner", 32'(owner), 32'h2);
            check("t1_en",    32'(en),    32'h0);
            tick();
        end
        check("t1_ready_back", 32'(job_ready), 32'hF);
        check("t1_idle",       32'(busy),      32'h0);

        // All four clients at once: grant order 3,2,1,0, back-to-back bursts
        n = cyc;
        sb.push_back('{3, n + 5});
        sb.push_back('{2, n + 10});
        sb.push_back('{1, n + 15});
        sb.push_back('{0, n + 20});
        drive_jobs(4'b1111);
        check("t2_req", 32'(req), 32'hF);
        tick();
        for (int c = 0; c < 4; c++) begin
            check("t2_owner", 32'(owner), 32'(3 - c));
            check("t2_busy",  32'(busy),  32'h1);
            check("t2_en",    32'(en),    32'h0);
            tick(5);
        end
        check("t2_idle",  32'(busy),      32'h0);
        check("t2_ready", 32'(job_ready), 32'hF);

        // Request arriving while client 0 owns waits for the burst end
        n = cyc;
        sb.push_back('{0, n + 5});
        sb.push_back('{3, n + 10});
        drive_jobs(4'b0001);
        tick(2);
        drive_jobs(4'b1000);
        check("t3_req_wait",   32'(req),       32'b1000);
        check("t3_owner0",     32'(owner),     32'h0);
        check("t3_ready",      32'(job_ready), 32'b0110);
        tick();
        check("t3_req_hold",   32'(req),       32'b1000);
        check("t3_busy_last",  32'(busy),      32'h1);
        tick();
        check("t3_en_free",    32'(en),        32'h1);
        check("t3_req_grant",  32'(req),       32'b1000);
        tick();
        check("t3_owner3",     32'(owner),     32'h3);
        check("t3_busy3",      32'(busy),      32'h1);
        check("t3_req_clear",  32'(req),       32'h0);
        tick(4);
        check("t3_idle",       32'(busy),      32'h0);

        // Illegal multi-hot grant: sticky err, no state change
        check("t4_err_pre", 32'(err), 32'h0);
        force_on  = 1'b1;
        force_gnt = 4'b1111;
        tick();
        force_on  = 1'b0;
        check("t4_err_set",    32'(err),       32'h1);
        check("t4_ready_same", 32'(job_ready), 32'hF);
        check("t4_busy_same",  32'(busy),      32'h0);
        check("t4_req_same",   32'(req),       32'h0);
        tick(3);
        check("t4_err_sticky", 32'(err), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t4_err_cleared", 32'(err), 32'h0);
        tick();

        // One-hot grant to a client that is not requesting
        force_on  = 1'b1;
        force_gnt = 4'b0010;
        tick();
        force_on  = 1'b0;
        check("t4b_err",   32'(err),       32'h1);
        check("t4b_busy",  32'(busy),      32'h0);
        check("t4b_ready", 32'(job_ready), 32'hF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // Grant while en is low (client 0 owns) is ignored and flagged
        n = cyc;
        sb.push_back('{0, n + 5});
        drive_jobs(4'b0001);
        tick();
        force_on  = 1'b1;
        force_gnt = 4'b0001;
        tick();
        force_on  = 1'b0;
        check("t4c_err",   32'(err),   32'h1);
        check("t4c_owner", 32'(owner), 32'h0);
        check("t4c_busy",  32'(busy),  32'h1);
        tick(4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // Reset in the second OWN cycle abandons the burst without a done pulse
        n = cyc;
        drive_jobs(4'b0010);
        tick(2);
        check("t5_busy_pre",  32'(busy),  32'h1);
        check("t5_owner_pre", 32'(owner), 32'h1);
        reset = 1'b1;
        tick();
        check("t5_busy",  32'(busy),      32'h0);
        check("t5_req",   32'(req),       32'h0);
        check("t5_done",  32'(done),      32'h0);
        check("t5_ready", 32'(job_ready), 32'hF);
        check("t5_owner", 32'(owner),     32'h0);
        reset = 1'b0;
        tick(6);
        check("t5_stay_idle", 32'(busy), 32'h0);

`ifdef REQ_STARVE_DETECT_EN
        // Client 0 starves behind clients 3 and 2 refilling continuously
        begin
            logic prev;
            bit   found;
            mon_on = 1'b0;
            prev   = 1'b0;
            found  = 1'b0;
            job_valid = 4'b1101;
            tick();
            job_valid = 4'b1100;
            tick(15);
            check("t6_starve_before", 32'(starve[0]), 32'h0);
            tick();
            check("t6_starve_set", 32'(starve[0]), 32'h1);
            job_valid = 4'b0000;
            for (int k = 0; k < 100; k++) begin
                prev = starve[0];
                tick();
                if (busy && owner == 2'd0) begin
                    found = 1'b1;
                    break;
                end
            end
            check("t6_grant_seen",     32'(found),     32'h1);
            check("t6_starve_at_gnt",  32'(prev),      32'h1);
            check("t6_starve_cleared", 32'(starve[0]), 32'h0);
            tick(6);
            reset = 1'b1;
            tick();
            reset  = 1'b0;
            mon_on = 1'b1;
            tick();
        end
`endif

        tick(3);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
